// File: rtl/serial_arith_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_arith_pkg
// Description : Shared types and limits for the bit-serial arithmetic cells.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_arith_pkg;

    localparam int SERIAL_MAX_WIDTH = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage : serial_arith_pkg
`default_nettype wire

// File: rtl/full_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : full_subtractor
// Description : One-bit full subtractor computing a - b - bin.
// Revision    : 1.0 - initial release
// ============================================================================
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule : full_subtractor
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor
// Description : LSB-first bit-serial unsigned subtractor, diff = a - b - bin.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             ready,
    output logic             busy,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             valid
);

    localparam int                 c_CNT_W    = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);

    if ((WIDTH < 2) || (WIDTH > SERIAL_MAX_WIDTH)) begin : g_width_check
        $error("serial_subtractor: WIDTH out of range");
    end

    state_e             r_state;
    state_e             w_state_next;
    logic               w_accept;
    logic               w_last;

    logic [WIDTH-1:0]   r_a_sr;
    logic [WIDTH-1:0]   r_b_sr;
    logic               r_br;
    logic [c_CNT_W-1:0] r_cnt;
    // Holds the WIDTH-1 bits already produced; the cell output supplies the MSB.
    logic [WIDTH-2:0]   r_res;
    logic [WIDTH-1:0]   r_diff;
    logic               r_bout;

    logic               w_cell_d;
    logic               w_cell_bout;
    logic [WIDTH-1:0]   w_res_next;

    full_subtractor u_cell (
        .a    (r_a_sr[0]),
        .b    (r_b_sr[0]),
        .bin  (r_br),
        .d    (w_cell_d),
        .bout (w_cell_bout)
    );

    assign w_res_next = {w_cell_d, r_res};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        ready        = 1'b0;
        busy         = 1'b0;
        valid        = 1'b0;
        case (r_state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (r_cnt == c_CNT_LAST) begin
                    w_last       = 1'b1;
                    w_state_next = DONE;
                end
            end
            DONE: begin
                busy         = 1'b1;
                valid        = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_sr <= '0;
            r_b_sr <= '0;
            r_br   <= 1'b0;
            r_cnt  <= '0;
            r_res  <= '0;
            r_diff <= '0;
            r_bout <= 1'b0;
        end else if (w_accept) begin
            r_a_sr <= a;
            r_b_sr <= b;
            r_br   <= bin;
            r_cnt  <= '0;
            r_res  <= '0;
        end else if (r_state == RUN) begin
            r_a_sr <= {1'b0, r_a_sr[WIDTH-1:1]};
            r_b_sr <= {1'b0, r_b_sr[WIDTH-1:1]};
            r_br   <= w_cell_bout;
            r_cnt  <= r_cnt + 1'b1;
            r_res  <= w_res_next[WIDTH-1:1];
            if (w_last) begin
                r_diff <= w_res_next;
                r_bout <= w_cell_bout;
            end
        end
    end

    assign diff = r_diff;
    assign bout = r_bout;

endmodule : serial_subtractor
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_subtractor
// Description : Directed self-checking bench for serial_subtractor (WIDTH 8 and 2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

    logic       clk;
    logic       rst;
    logic       s_start, s_bin;
    logic [7:0] s_a, s_b;
    logic       ready8, busy8, bout8, valid8;
    logic [7:0] diff8;
    logic       s2_start, s2_bin;
    logic [1:0] s2_a, s2_b;
    logic       ready2, busy2, bout2, valid2;
    logic [1:0] diff2;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] exp_prev;
    int         cyc;
    int         nvalid;
    logic [7:0] qa [4];
    logic [7:0] qb [4];
    logic       qbin [4];
    logic [8:0] r9;
    logic [2:0] r3;

    serial_subtractor #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(s_start), .a(s_a), .b(s_b), .bin(s_bin),
        .ready(ready8), .busy(busy8), .diff(diff8), .bout(bout8), .valid(valid8)
    );

    serial_subtractor #(.WIDTH(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(s2_start), .a(s2_a), .b(s2_b), .bin(s2_bin),
        .ready(ready2), .busy(busy2), .diff(diff2), .bout(bout2), .valid(valid2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issues one WIDTH=8 operation from IDLE and checks timing and result.
    task automatic op8(input string tag, input logic [7:0] ta, input logic [7:0] tb_b,
                       input logic tbin, input logic [7:0] ed, input logic eb);
        int c;
        int rdy_hi;
        int unstable;
        s_a = ta; s_b = tb_b; s_bin = tbin; s_start = 1'b1;
        tick();
        s_start = 1'b0; s_a = ~ta; s_b = ~tb_b; s_bin = ~tbin;
        c = 0; rdy_hi = 0; unstable = 0;
        while (!valid8 && c < 20) begin
            if (ready8) rdy_hi++;
            if (diff8 !== exp_prev) unstable++;
            tick();
            c++;
        end
        check({tag, " latency"}, c, 8);
        check({tag, " ready_low_run"}, rdy_hi, 0);
        check({tag, " diff_stable_run"}, unstable, 0);
        check({tag, " ready_in_done"}, ready8, 1'b0);
        check({tag, " diff"}, diff8, ed);
        check({tag, " bout"}, bout8, eb);
        tick();
        check({tag, " ready_after"}, ready8, 1'b1);
        check({tag, " valid_after"}, valid8, 1'b0);
        exp_prev = ed;
    endtask

    initial begin
        rst = 1'b1; s_start = 1'b0; s_a = '0; s_b = '0; s_bin = 1'b0;
        s2_start = 1'b0; s2_a = '0; s2_b = '0; s2_bin = 1'b0;
        tick(); tick(); tick();
        check("reset ready", ready8, 1'b1);
        check("reset busy", busy8, 1'b0);
        check("reset valid", valid8, 1'b0);
        check("reset diff", diff8, 8'h00);
        check("reset bout", bout8, 1'b0);
        rst = 1'b0;
        exp_prev = 8'h00;

        op8("t1", 8'h5A, 8'h23, 1'b0, 8'h37, 1'b0);
        op8("t2a", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1);
        op8("t2b", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
        op8("t2c", 8'h80, 8'h7F, 1'b1, 8'h00, 1'b0);

        // starts during RUN and DONE must be ignored
        s_a = 8'h10; s_b = 8'h01; s_bin = 1'b0; s_start = 1'b1;
        tick();
        s_start = 1'b0;
        cyc = 0;
        while (!valid8 && cyc < 20) begin
            s_start = (cyc == 2);
            s_a = 8'hAA; s_b = 8'h55; s_bin = 1'b1;
            tick();
            cyc++;
        end
        check("t3 latency", cyc, 8);
        check("t3 diff", diff8, 8'h0F);
        check("t3 bout", bout8, 1'b0);
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        check("t3 ready_after", ready8, 1'b1);
        check("t3 busy_after", busy8, 1'b0);
        nvalid = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (valid8) nvalid++;
        end
        check("t3 extra_valid", nvalid, 0);

        // reset during RUN abandons the operation
        s_a = 8'h44; s_b = 8'h11; s_bin = 1'b0; s_start = 1'b1;
        tick();
        s_start = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t4 ready", ready8, 1'b1);
        check("t4 busy", busy8, 1'b0);
        check("t4 valid", valid8, 1'b0);
        check("t4 diff", diff8, 8'h00);
        check("t4 bout", bout8, 1'b0);
        nvalid = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (valid8) nvalid++;
        end
        check("t4 no_valid", nvalid, 0);
        exp_prev = 8'h00;
        op8("t4b", 8'h09, 8'h03, 1'b0, 8'h06, 1'b0);

        // start held high: accepts every WIDTH+2 cycles
        for (int i = 0; i < 40; i++) begin
            s_start = 1'b1;
            s_a = 8'(i * 37 + 5);
            s_b = 8'(i * 91 + 200);
            s_bin = i[0];
            if (i % 10 == 0) begin
                qa[i / 10] = s_a; qb[i / 10] = s_b; qbin[i / 10] = s_bin;
            end
            tick();
            check("t5 valid", valid8, (i % 10 == 8));
            if (i % 10 == 8) begin
                r9 = {1'b0, qa[i / 10]} - {1'b0, qb[i / 10]} - 9'(qbin[i / 10]);
                check("t5 diff", diff8, r9[7:0]);
                check("t5 bout", bout8, r9[8]);
            end
        end
        s_start = 1'b0;
        tick();
        check("t5 idle", ready8, 1'b1);

        // WIDTH=2 exhaustive
        for (int k = 0; k < 32; k++) begin
            s2_a = k[4:3]; s2_b = k[2:1]; s2_bin = k[0];
            s2_start = 1'b1;
            tick();
            s2_start = 1'b0;
            r3 = {1'b0, k[4:3]} - {1'b0, k[2:1]} - 3'(k[0]);
            s2_a = ~k[4:3]; s2_b = ~k[2:1]; s2_bin = ~k[0];
            cyc = 0;
            while (!valid2 && cyc < 10) begin
                tick();
                cyc++;
            end
            check("w2 latency", cyc, 2);
            check("w2 diff", diff2, r3[1:0]);
            check("w2 bout", bout2, r3[2]);
            tick();
            check("w2 single_valid", valid2, 1'b0);
            check("w2 ready", ready2, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_serial_subtractor
`default_nettype wire

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial unsigned subtractor: the inverse operation of the team's full-adder datapath cell.
- Computes `diff = a - b - bin` over WIDTH bits, LSB first, one bit per clock.
- The datapath is a single full-subtractor cell plus a borrow flip-flop.
- Sits beside the adder in the small-arithmetic library; uses a start/ready/valid handshake so a controller can issue operations without a parallel subtractor.

Parameters:
- WIDTH, 8, operand and result width in bits. Legal range is 2 to 64.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; accepted only on a rising edge where `ready`=1.
- a  in  WIDTH  minuend, sampled on the accepting edge.
- b  in  WIDTH  subtrahend, sampled on the accepting edge.
- bin  in  1  initial borrow-in, sampled on the accepting edge.
- ready  out  1  high only in IDLE.
- busy  out  1  high in RUN and DONE.
- diff  out  WIDTH  registered result; holds until the next completion.
- bout  out  1  final borrow-out; holds with `diff`.
- valid  out  1  one-cycle pulse when `diff`/`bout` are newly updated.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values:
  - state=IDLE, `ready`=1, `busy`=0, `valid`=0.
  - `diff`=0, `bout`=0.
  - Internal shift registers, borrow FF and counter all cleared to 0.
- Reset has priority over every other input on the same edge.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If `start`=1 on an edge, load `a`/`b` into operand shift registers, borrow FF ← `bin`, counter ← 0, go to RUN.
  - Otherwise remain in IDLE.
- RUN, each cycle:
  - cell inputs are `a_sr[0]`, `b_sr[0]`, borrow FF.
  - `d = a0 ^ b0 ^ br`.
  - `br_next = (~a0 & b0) | (~(a0 ^ b0) & br)`.
  - Shift both operands right by one.
  - Shift `d` into bit WIDTH-1 of the result shift register, which shifts right.
  - borrow FF ← `br_next`; counter increments.
  - When the counter reaches WIDTH-1 on an edge, go to DONE on that edge.
  - On that same edge, load the output registers: `diff` ← final result shift value (including the last bit), `bout` ← `br_next`.
- DONE: lasts exactly one cycle.
  - `valid`=1, `busy`=1, `ready`=0.
  - Next state is IDLE unconditionally.
- Latency: start accepted at edge k → `valid` high in the cycle after edge k+WIDTH (WIDTH+1 cycles from acceptance to the `valid` cycle). `ready` returns high the following cycle.
- Throughput: one operation per WIDTH+2 cycles.
- `start` while not `ready` (RUN or DONE) is ignored. It is not queued, and operands presented then are not sampled.
- `start` held high continuously: a new operation is accepted on the first edge `ready`=1.
- `diff`/`bout` change only on the edge entering DONE. They are stable throughout RUN and show the previous result.
- Arithmetic: `diff` = (a − b − bin) mod 2^WIDTH. `bout`=1 iff unsigned a < b + bin.
- Counter width is `$clog2(WIDTH)`; no wrap hazard, because the counter is cleared on acceptance.
- Reset mid-RUN or in DONE: the operation is abandoned, no `valid` is issued, and outputs go to reset values on that edge. `ready`=1 in the following cycle.

Decomposition:
- Shared package `serial_arith_pkg`:
  - state enum {IDLE, RUN, DONE} (2-bit);
  - localparam `SERIAL_MAX_WIDTH` = 64.
- Sub-module `full_subtractor`: combinational a, b, bin → d, bout. It is the dual of the existing full-adder cell and is instantiated once in the datapath.
- The FSM, counter and shift registers stay in the top module.

Test Plan:
- WIDTH=8, a=0x5A, b=0x23, bin=0, start at edge k → `valid` pulse one cycle after edge k+8, `diff`=0x37, `bout`=0; `ready` low during k+1..k+9 cycles, high after.
- a=0x00, b=0x01, bin=0 → `diff`=0xFF, `bout`=1. Then a=0xFF, b=0xFF, bin=1 → `diff`=0xFF, `bout`=1. Then a=0x80, b=0x7F, bin=1 → `diff`=0x00, `bout`=0.
- Issue a=0x10, b=0x01; pulse `start` with a=0xAA, b=0x55 during RUN cycle 3 and again during DONE → both ignored; single `valid` with `diff`=0x0F, `bout`=0.
- Assert `rst` for one cycle during RUN cycle 4 → no `valid`, `diff`=0, `bout`=0, `ready`=1 next cycle. New op a=0x09, b=0x03 → `diff`=0x06.
- `start` held high continuously with changing operands → accepted only on `ready` edges, one result every 10 cycles (WIDTH=8), each matching the operands present at its accepting edge.
- WIDTH=2 exhaustive: all 32 (a, b, bin) combos back-to-back against a reference model (a−b−bin) → `diff`/`bout` match, exactly one `valid` per op.
